// File: rtl/reveal_cells.sv
`default_nettype none
// ============================================================================
// Module      : reveal_cells
// Description : Flood-reveal engine for the minesweeper board. Reveals the
//               clicked cell and, when it has no adjacent mines, walks the
//               connected zero region breadth-first through an internal
//               coordinate FIFO. Each reveal is written one cell per cycle
//               through the shared x/y board address.
// Ports       : clk, reset (sync, active-low)
//               start, clickX, clickY       - begin a reveal at the click
//               x, y                        - registered board address
//               mineBoardReadValue          - mine flag at (x,y)
//               numBoardReadValue           - adjacent-mine count at (x,y)
//               revealBoardReadValue        - reveal flag at (x,y)
//               revealBoardWriteEn          - write 1 to reveal board at (x,y)
//               hitMine, revealedCount      - result, valid while done
//               done, ack                   - completion handshake
// Revision    : 1.0 - initial release
// ============================================================================
module reveal_cells #(
    parameter int boardWidth  = 8,
    parameter int boardHeight = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [$clog2(boardWidth)-1:0]               clickX,
    input  logic [$clog2(boardHeight)-1:0]              clickY,
    output logic [$clog2(boardWidth)-1:0]               x,
    output logic [$clog2(boardHeight)-1:0]              y,
    input  logic                                        mineBoardReadValue,
    input  logic [3:0]                                  numBoardReadValue,
    input  logic                                        revealBoardReadValue,
    output logic                                        revealBoardWriteEn,
    output logic                                        hitMine,
    output logic [$clog2(boardWidth*boardHeight+1)-1:0] revealedCount,
    output logic                                        done,
    input  logic                                        ack
);

    localparam int XW    = $clog2(boardWidth);
    localparam int YW    = $clog2(boardHeight);
    localparam int CELLS = boardWidth * boardHeight;
    localparam int CW    = $clog2(CELLS + 1);
    localparam int PW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int EW    = XW + YW;

    localparam logic [XW-1:0] c_X_MAX   = XW'(boardWidth - 1);
    localparam logic [YW-1:0] c_Y_MAX   = YW'(boardHeight - 1);
    localparam logic [PW-1:0] c_PTR_MAX = PW'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_POP   = 3'd2,
        S_SET_N = 3'd3,
        S_TEST_N= 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [XW-1:0]   r_cx;
    logic [YW-1:0]   r_cy;
    logic [2:0]      r_k;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_occ;
    logic [CW-1:0]   r_count;
    logic            r_hit;
    logic [EW-1:0]   r_fifo [CELLS];

    logic            w_fresh;
    logic            w_zero;
    logic            w_push;
    logic            w_we;
    logic            w_dxm;
    logic            w_dxp;
    logic            w_dym;
    logic            w_dyp;
    logic            w_off;
    logic [XW-1:0]   w_nx;
    logic [YW-1:0]   w_ny;
    logic [PW-1:0]   w_tail_nxt;
    logic [PW-1:0]   w_head_nxt;

    // A cell is worth revealing only if it is neither revealed nor a mine.
    assign w_fresh = !revealBoardReadValue && !mineBoardReadValue;
    assign w_zero  = (numBoardReadValue == 4'd0);

    // The write and the push happen in the same cycle, so the reveal flag
    // doubles as the "already queued" marker and no cell is queued twice.
    assign w_we   = ((r_state == S_CHECK) && !revealBoardReadValue) ||
                    ((r_state == S_TEST_N) && w_fresh);
    assign w_push = ((r_state == S_CHECK) || (r_state == S_TEST_N)) &&
                    w_fresh && w_zero;

    // Neighbour offsets for k = 0..7:
    // (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
    assign w_dxm = (r_k == 3'd0) || (r_k == 3'd3) || (r_k == 3'd5);
    assign w_dxp = (r_k == 3'd2) || (r_k == 3'd4) || (r_k == 3'd7);
    assign w_dym = (r_k <= 3'd2);
    assign w_dyp = (r_k >= 3'd5);

    assign w_off = (w_dxm && (r_cx == '0))      || (w_dxp && (r_cx == c_X_MAX)) ||
                   (w_dym && (r_cy == '0))      || (w_dyp && (r_cy == c_Y_MAX));

    // Arithmetic may wrap here, but wrapped values are only used when w_off
    // is low, i.e. when the neighbour really is on the board.
    assign w_nx = w_dxm ? (r_cx - 1'b1) : (w_dxp ? (r_cx + 1'b1) : r_cx);
    assign w_ny = w_dym ? (r_cy - 1'b1) : (w_dyp ? (r_cy + 1'b1) : r_cy);

    assign w_tail_nxt = (r_tail == c_PTR_MAX) ? '0 : (r_tail + 1'b1);
    assign w_head_nxt = (r_head == c_PTR_MAX) ? '0 : (r_head + 1'b1);

    // FIFO storage needs no reset; occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= {r_x, r_y};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_k     <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_count <= '0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= clickX;
                        r_y     <= clickY;
                        r_count <= '0;
                        r_hit   <= 1'b0;
                        r_head  <= '0;
                        r_tail  <= '0;
                        r_occ   <= '0;
                        r_k     <= '0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (revealBoardReadValue) begin
                        r_state <= S_DONE;
                    end else if (mineBoardReadValue) begin
                        r_hit   <= 1'b1;
                        r_count <= CW'(1);
                        r_state <= S_DONE;
                    end else begin
                        r_count <= CW'(1);
                        if (w_zero) begin
                            r_tail  <= w_tail_nxt;
                            r_occ   <= r_occ + 1'b1;
                            r_state <= S_POP;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_POP: begin
                    if (r_occ == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        {r_cx, r_cy} <= r_fifo[r_head];
                        r_head  <= w_head_nxt;
                        r_occ   <= r_occ - 1'b1;
                        r_k     <= '0;
                        r_state <= S_SET_N;
                    end
                end
                S_SET_N: begin
                    if (w_off) begin
                        r_k <= r_k + 1'b1;
                        if (r_k == 3'd7) begin
                            r_state <= S_POP;
                        end
                    end else begin
                        r_x     <= w_nx;
                        r_y     <= w_ny;
                        r_state <= S_TEST_N;
                    end
                end
                S_TEST_N: begin
                    if (w_fresh) begin
                        r_count <= r_count + 1'b1;
                        if (w_zero) begin
                            r_tail <= w_tail_nxt;
                            r_occ  <= r_occ + 1'b1;
                        end
                    end
                    if (r_k == 3'd7) begin
                        r_state <= S_POP;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_SET_N;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x                  = r_x;
    assign y                  = r_y;
    assign revealBoardWriteEn = w_we;
    assign hitMine            = r_hit;
    assign revealedCount      = r_count;
    assign done               = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_reveal_cells.sv
`default_nettype none
// ============================================================================
// Module      : tb_reveal_cells
// Description : Scoreboard bench for reveal_cells. The driver pushes the
//               expected result of each reveal into a queue; a monitor pops
//               and compares whenever done rises. A board model answers the
//               DUT's combinational reads and records every write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reveal_cells;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    typedef struct {
        int cnt;
        int hit;
        int lat;
        int t0;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic       ack    = 1'b0;
    logic [2:0] clickX = '0;
    logic [2:0] clickY = '0;
    logic [2:0] x;
    logic [2:0] y;
    logic       mineBoardReadValue;
    logic [3:0] numBoardReadValue;
    logic       revealBoardReadValue;
    logic       revealBoardWriteEn;
    logic       hitMine;
    logic [6:0] revealedCount;
    logic       done;

    logic       mine_b   [N] = '{default: 1'b0};
    logic [3:0] num_b    [N] = '{default: 4'd0};
    logic       reveal_b [N] = '{default: 1'b0};
    int         wcnt     [N] = '{default: 0};
    int         base     [N];
    int         wtotal   = 0;
    int         base_total;
    int         cyc      = 0;
    logic       clr_req  = 1'b0;
    logic       set_req  = 1'b0;
    int         set_idx  = 0;

    int         total = 0;
    int         bad   = 0;
    exp_t       q [$];

    reveal_cells #(.boardWidth(W), .boardHeight(H)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .clickX               (clickX),
        .clickY               (clickY),
        .x                    (x),
        .y                    (y),
        .mineBoardReadValue   (mineBoardReadValue),
        .numBoardReadValue    (numBoardReadValue),
        .revealBoardReadValue (revealBoardReadValue),
        .revealBoardWriteEn   (revealBoardWriteEn),
        .hitMine              (hitMine),
        .revealedCount        (revealedCount),
        .done                 (done),
        .ack                  (ack)
    );

    always #5 clk = ~clk;

    assign mineBoardReadValue   = mine_b[{y, x}];
    assign numBoardReadValue    = num_b[{y, x}];
    assign revealBoardReadValue = reveal_b[{y, x}];

    // Board model: reveal memory plus per-cell write counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_req) begin
            for (int i = 0; i < N; i++) reveal_b[i] <= 1'b0;
        end else if (set_req) begin
            reveal_b[set_idx] <= 1'b1;
        end else if (revealBoardWriteEn) begin
            reveal_b[{y, x}] <= 1'b1;
        end
        if (revealBoardWriteEn) begin
            wcnt[{y, x}] <= wcnt[{y, x}] + 1;
            wtotal       <= wtotal + 1;
        end
    end

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: compare result fields on every rising edge of done.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("revealedCount", int'(revealedCount), e.cnt);
                    check("hitMine", int'(hitMine), e.hit);
                    if (e.lat >= 0) check("done_latency", cyc - e.t0, e.lat);
                end
            end
            prev = done;
        end
    end

    function automatic int idx(input int xx, input int yy);
        return yy * W + xx;
    endfunction

    task automatic clear_board();
        @(negedge clk);
        clr_req = 1'b1;
        for (int i = 0; i < N; i++) begin
            mine_b[i] = 1'b0;
            num_b[i]  = 4'd0;
        end
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic preset_reveal(input int i);
        @(negedge clk);
        set_req = 1'b1;
        set_idx = i;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    task automatic snap();
        for (int i = 0; i < N; i++) base[i] = wcnt[i];
        base_total = wtotal;
    endtask

    task automatic click(input int cx, input int cy, input int ecnt,
                         input int ehit, input int elat, input bit expect_it);
        exp_t e;
        @(negedge clk);
        clickX = 3'(cx);
        clickY = 3'(cy);
        start  = 1'b1;
        if (expect_it) begin
            e.cnt = ecnt;
            e.hit = ehit;
            e.lat = elat;
            e.t0  = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("done_after_ack", int'(done), 0);
    endtask

    initial begin
        int nbad;
        int lowcnt;
        int wt;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(revealBoardWriteEn), 0);
        check("rst_count", int'(revealedCount), 0);
        check("rst_hit", int'(hitMine), 0);
        check("rst_xy", int'({y, x}), 0);
        reset = 1'b1;

        // Clicked cell already revealed
        clear_board();
        preset_reveal(idx(2, 2));
        snap();
        click(2, 2, 0, 0, 2, 1'b1);
        wait_done("already");
        check("already_writes", wtotal - base_total, 0);
        do_ack();

        // Mine hit
        clear_board();
        mine_b[idx(3, 4)] = 1'b1;
        snap();
        click(3, 4, 1, 1, 2, 1'b1);
        wait_done("mine");
        check("mine_writes", wtotal - base_total, 1);
        check("mine_write_at_3_4", wcnt[idx(3, 4)] - base[idx(3, 4)], 1);
        do_ack();

        // Numbered cell: single write, no flood
        clear_board();
        num_b[idx(5, 5)] = 4'd2;
        snap();
        click(5, 5, 1, 0, 2, 1'b1);
        wait_done("number");
        check("number_writes", wtotal - base_total, 1);
        check("number_write_at_5_5", wcnt[idx(5, 5)] - base[idx(5, 5)], 1);
        do_ack();

        // Empty board flood: 1 CHECK + 64 POP + 1 final POP
        // + 2*420 on-board + 92 off-board neighbour cycles -> done at 999
        clear_board();
        snap();
        click(0, 0, 64, 0, 999, 1'b1);
        wait_done("empty");
        nbad = 0;
        for (int i = 0; i < N; i++) if (wcnt[i] - base[i] != 1) nbad++;
        check("empty_cells_not_once", nbad, 0);
        check("empty_writes", wtotal - base_total, 64);
        do_ack();

        // Single mine at (7,7) with counts around it
        clear_board();
        mine_b[idx(7, 7)] = 1'b1;
        num_b[idx(6, 6)]  = 4'd1;
        num_b[idx(7, 6)]  = 4'd1;
        num_b[idx(6, 7)]  = 4'd1;
        snap();
        click(0, 0, 63, 0, -1, 1'b1);
        wait_done("onemine");
        check("onemine_7_7_writes", wcnt[idx(7, 7)] - base[idx(7, 7)], 0);
        nbad = 0;
        for (int i = 0; i < N - 1; i++) if (wcnt[i] - base[i] != 1) nbad++;
        check("onemine_cells_not_once", nbad, 0);
        // Hold ack low with start pulses: done and results must hold
        snap();
        lowcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start  = (i % 2 == 0);
            clickX = 3'd4;
            clickY = 3'd4;
            if (!done) lowcnt++;
        end
        @(negedge clk);
        start = 1'b0;
        if (!done) lowcnt++;
        check("hold_done_low_cycles", lowcnt, 0);
        check("hold_count", int'(revealedCount), 63);
        check("hold_hit", int'(hitMine), 0);
        check("hold_writes", wtotal - base_total, 0);
        do_ack();

        // Reset mid-flood
        clear_board();
        snap();
        click(0, 0, 0, 0, -1, 1'b0);
        repeat (39) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_done", int'(done), 0);
        check("midrst_we", int'(revealBoardWriteEn), 0);
        check("midrst_count", int'(revealedCount), 0);
        wt = wtotal;
        check("midrst_some_committed", int'((wt - base_total > 0) && (wt - base_total < 64)), 1);
        repeat (2) @(negedge clk);
        check("midrst_no_writes_after", wtotal - wt, 0);
        reset = 1'b1;

        // New reveal after reset completes normally
        clear_board();
        snap();
        click(0, 0, 64, 0, 999, 1'b1);
        wait_done("after_rst");
        check("after_rst_writes", wtotal - base_total, 64);
        do_ack();

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reveal_cells.md
# reveal_cells

Flood-reveal engine for the minesweeper board, sitting directly downstream of mine placement. After the mine board and adjacent-count board are populated, each player click is handed to this block. It reveals the clicked cell and, if that cell has zero adjacent mines, breadth-first reveals the connected zero region and its numbered border, writing the reveal board one cell at a time. It shares the x/y board-addressing style of the mine-placement stage, and the board memories are multiplexed to it after placement reports done.

## Interface
- boardWidth, 8, columns; power of 2
- boardHeight, 8, rows; power of 2
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a reveal at clickX/clickY; sampled only in IDLE
- clickX  in  $clog2(boardWidth)  clicked column
- clickY  in  $clog2(boardHeight)  clicked row
- x  out  $clog2(boardWidth)  registered board address, column; shared by reads and writes
- y  out  $clog2(boardHeight)  registered board address, row
- mineBoardReadValue  in  1  combinational read of mine board at (x,y)
- numBoardReadValue  in  4  combinational read of adjacent-mine count at (x,y), range 0..8
- revealBoardReadValue  in  1  combinational read of reveal board at (x,y)
- revealBoardWriteEn  out  1  combinational; board writes 1 to (x,y) at the end of the cycle
- hitMine  out  1  registered; clicked cell was a mine; valid while done
- revealedCount  out  $clog2(boardWidth*boardHeight+1)  cells newly revealed by this operation
- done  out  1  high in DONE state
- ack  in  1  releases DONE back to IDLE

## Operation
- Internal coordinate FIFO: depth boardWidth*boardHeight, one {x,y} entry each, circular head/tail pointers plus an occupancy count.
- A cell is written as revealed in the same cycle it is pushed, so no cell is pushed twice and the FIFO cannot overflow.
- Push and pop never occur in the same cycle.
- Neighbour order, k=0..7: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1).
- Neighbours falling off the board are skipped. There is no wrap-around.
- States:
  - IDLE
    - On start: latch clickX/clickY into x/y; clear revealedCount, hitMine and the FIFO.
    - Go to CHECK.
  - CHECK (addresses the clicked cell)
    - If revealBoardReadValue=1: no write; go to DONE.
    - Else if mineBoardReadValue=1: assert writeEn; hitMine<=1; count<=1; go to DONE.
    - Else: assert writeEn; count<=1.
      - If numBoardReadValue=0: push the cell; go to POP.
      - Otherwise: go to DONE.
  - POP
    - If the FIFO is empty, go to DONE.
    - Otherwise pop into the centre register (cx,cy), set k=0, and go to SET_N.
  - SET_N
    - If neighbour k is off-board: k<=k+1; if k=7, go to POP.
    - Otherwise: x/y<=neighbour; go to TEST_N.
  - TEST_N
    - If the cell is not revealed and not a mine: assert writeEn; count<=count+1; if numBoardReadValue=0, push the cell.
    - Then: if k=7, go to POP; else k<=k+1 and go to SET_N.
  - DONE
    - done=1; outputs are held.
    - On ack, go to IDLE.
- Input qualification:
  - start is ignored outside IDLE.
  - ack is ignored outside DONE.
  - In DONE only ack is examined.
- revealBoardWriteEn is high only in CHECK or TEST_N, and only under the conditions above.

## Timing
- Reset values:
  - state=IDLE, x=0, y=0, k=0
  - FIFO empty, revealedCount=0
  - hitMine=0, done=0, revealBoardWriteEn=0
- Reset mid-operation:
  - Aborts to IDLE on the next edge.
  - Writes already committed remain in the reveal board.
  - No writeEn occurs after the reset edge.
- Single-cell reveal latency:
  - Cycle 0: start is sampled.
  - Cycle 1: CHECK, with writeEn high.
  - Cycle 2 onward: done=1.
- Flood cost:
  - Each popped cell takes 1 POP cycle.
  - Each on-board neighbour takes 2 cycles; each off-board neighbour takes 1.
  - One final POP cycle sees the FIFO empty.
  - Worst case on an 8x8 board is under 1200 cycles.
- done stays high until the cycle after ack is sampled.
- revealedCount and hitMine are stable from done rising until the next start.

## Test plan
- Clicked cell already revealed, start at (2,2):
  - Required: done at cycle 2, revealedCount=0, hitMine=0, no writeEn pulse.
- Mine at (3,4), click (3,4):
  - Required: exactly one writeEn, at x=3, y=4; hitMine=1; revealedCount=1; done at cycle 2.
- Cell (5,5) with numBoard=2, click (5,5):
  - Required: one write, revealedCount=1, no FIFO activity, done at cycle 2.
- Empty board, no mines, click (0,0):
  - Required: all 64 cells written exactly once, revealedCount=64, no FIFO overflow.
  - Required: no write to any off-board coordinate, including at corners and edges.
- Single mine at (7,7) with counts set, click (0,0):
  - Required: revealedCount=63, (7,7) never written, hitMine=0.
  - Then hold ack low for 10 cycles. Required: done held high; start pulses are ignored.
- Reset mid-operation:
  - Assert reset low during the flood at cycle 40. Required: next edge gives IDLE, done=0, writeEn=0, revealedCount=0.
  - Then issue a new start. Required: the new reveal completes normally.
